// File: rtl/maze_mem_arbiter.sv
// Round-robin arbiter sharing one registered maze memory port between two solvers.
module maze_mem_arbiter #(
  parameter int unsigned maze_width = 6,
  parameter int unsigned cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [maze_width-1:0] row0,
  input  logic [maze_width-1:0] col0,
  input  logic [maze_width-1:0] row1,
  input  logic [maze_width-1:0] col1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rdata0,
  output logic                  rdata1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [maze_width-1:0] row,
  output logic [maze_width-1:0] col,
  output logic                  maze_oe,
  output logic                  maze_we,
  input  logic                  maze_in,
  output logic [cnt_width-1:0]  gcnt0,
  output logic [cnt_width-1:0]  gcnt1
);

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

  req_id_t                 prio;
  req_id_t                 tag;
  req_id_t                 winner;
  logic                    grant;
  logic [maze_width-1:0]   win_row;
  logic [maze_width-1:0]   win_col;
  logic                    win_we;

  // Grants are gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    grant   = 1'b0;
    winner  = prio;
    if (rst_n) begin
      if (req0 && (!req1 || prio == REQ0)) begin
        grant  = 1'b1;
        winner = REQ0;
      end else if (req1) begin
        grant  = 1'b1;
        winner = REQ1;
      end
    end
  end

  always_comb begin
    win_row = row0;
    win_col = col0;
    win_we  = we0;
    if (winner == REQ1) begin
      win_row = row1;
      win_col = col1;
      win_we  = we1;
    end
  end

  assign gnt0 = grant && (winner == REQ0);
  assign gnt1 = grant && (winner == REQ1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= REQ0;
    end else if (grant) begin
      prio <= (winner == REQ0) ? REQ1 : REQ0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row     <= '0;
      col     <= '0;
      maze_oe <= 1'b0;
      maze_we <= 1'b0;
      tag     <= REQ0;
    end else begin
      maze_oe <= 1'b0;
      maze_we <= 1'b0;
      if (grant) begin
        row     <= win_row;
        col     <= win_col;
        maze_oe <= !win_we;
        maze_we <= win_we;
        tag     <= winner;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0  <= 1'b0;
      rdata1  <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= maze_oe && (tag == REQ0);
      rvalid1 <= maze_oe && (tag == REQ1);
      if (maze_oe && tag == REQ0) begin
        rdata0 <= maze_in;
      end
      if (maze_oe && tag == REQ1) begin
        rdata1 <= maze_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt0 <= '0;
      gcnt1 <= '0;
    end else begin
      if (gnt0 && gcnt0 != '1) begin
        gcnt0 <= gcnt0 + CNT_ONE;
      end
      if (gnt1 && gcnt1 != '1) begin
        gcnt1 <= gcnt1 + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Randomized and directed checks of maze_mem_arbiter against an access-list model.
module tb_maze_mem_arbiter;

  localparam int unsigned MW = 6;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, we0, we1;
  logic [MW-1:0] row0, col0, row1, col1;
  logic          gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1;
  logic [MW-1:0] row, col;
  logic          maze_oe, maze_we, maze_in;
  logic [CW-1:0] gcnt0, gcnt1;

  logic          s_gnt0, s_gnt1, s_rdata0, s_rdata1, s_rvalid0, s_rvalid1;
  logic [MW-1:0] s_row, s_col;
  logic          s_maze_oe, s_maze_we, s_maze_in;
  logic [1:0]    s_gcnt0, s_gcnt1;

  logic          noise;
  bit            mem [0:63][0:63];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always_comb maze_in   = maze_oe   ? mem[row][col]     : noise;
  always_comb s_maze_in = s_maze_oe ? mem[s_row][s_col] : noise;

  maze_mem_arbiter #(.maze_width(MW), .cnt_width(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .row0(row0), .col0(col0), .row1(row1), .col1(col1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .row(row), .col(col),
    .maze_oe(maze_oe), .maze_we(maze_we), .maze_in(maze_in),
    .gcnt0(gcnt0), .gcnt1(gcnt1)
  );

  maze_mem_arbiter #(.maze_width(MW), .cnt_width(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .row0(row0), .col0(col0), .row1(row1), .col1(col1),
    .gnt0(s_gnt0), .gnt1(s_gnt1), .rdata0(s_rdata0), .rdata1(s_rdata1),
    .rvalid0(s_rvalid0), .rvalid1(s_rvalid1), .row(s_row), .col(s_col),
    .maze_oe(s_maze_oe), .maze_we(s_maze_we), .maze_in(s_maze_in),
    .gcnt0(s_gcnt0), .gcnt1(s_gcnt1)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: list of accepted accesses ----------------
  typedef struct {
    int g;   // cycle of the grant
    int id;
    bit rd;
    int r;
    int c;
    bit d;   // maze contents at the accessed cell
  } acc_t;

  acc_t acc_q[$];
  int   cyc;
  int   prio_m;
  int   last_row, last_col;
  int   cnt [2];
  bit   last_d [2];

  function automatic longint sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  always @(negedge clk) begin
    int w;
    bit e_oe, e_we;
    bit e_rv [2];
    acc_t a;
    if (!rst_n) begin
      acc_q.delete();
      cyc = 0; prio_m = 0; last_row = 0; last_col = 0;
      cnt[0] = 0; cnt[1] = 0; last_d[0] = 0; last_d[1] = 0;
      chk("rst_gnt0", gnt0, 0);
      chk("rst_gnt1", gnt1, 0);
      chk("rst_oe", maze_oe, 0);
      chk("rst_we", maze_we, 0);
      chk("rst_row", row, 0);
      chk("rst_col", col, 0);
      chk("rst_rvalid0", rvalid0, 0);
      chk("rst_rvalid1", rvalid1, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      chk("rst_gcnt0", gcnt0, 0);
      chk("rst_gcnt1", gcnt1, 0);
    end else begin
      w = -1;
      if (req0 && req1) w = prio_m;
      else if (req0)    w = 0;
      else if (req1)    w = 1;

      e_oe = 0; e_we = 0; e_rv[0] = 0; e_rv[1] = 0;
      foreach (acc_q[i]) begin
        if (acc_q[i].g == cyc - 1) begin
          e_oe = acc_q[i].rd;
          e_we = !acc_q[i].rd;
          last_row = acc_q[i].r;
          last_col = acc_q[i].c;
        end
        if (acc_q[i].g == cyc - 2 && acc_q[i].rd) begin
          e_rv[acc_q[i].id] = 1;
          last_d[acc_q[i].id] = acc_q[i].d;
        end
      end

      chk("gnt0", gnt0, w == 0);
      chk("gnt1", gnt1, w == 1);
      chk("maze_oe", maze_oe, e_oe);
      chk("maze_we", maze_we, e_we);
      chk("row", row, last_row);
      chk("col", col, last_col);
      chk("rvalid0", rvalid0, e_rv[0]);
      chk("rvalid1", rvalid1, e_rv[1]);
      chk("rdata0", rdata0, last_d[0]);
      chk("rdata1", rdata1, last_d[1]);
      chk("gcnt0", gcnt0, sat(cnt[0], 65535));
      chk("gcnt1", gcnt1, sat(cnt[1], 65535));
      chk("sat_gcnt0", s_gcnt0, sat(cnt[0], 3));
      chk("sat_gcnt1", s_gcnt1, sat(cnt[1], 3));

      while (acc_q.size() > 0 && acc_q[0].g < cyc - 1) void'(acc_q.pop_front());

      if (w >= 0) begin
        a.g  = cyc;
        a.id = w;
        a.rd = (w == 0) ? !we0 : !we1;
        a.r  = (w == 0) ? int'(row0) : int'(row1);
        a.c  = (w == 0) ? int'(col0) : int'(col1);
        a.d  = mem[a.r][a.c];
        acc_q.push_back(a);
        cnt[w]++;
        prio_m = 1 - w;
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    tick();
    tick();
    rst_n = 1;
  endtask

  logic g0, g1;

  initial begin
    rst_n = 0; idle(); noise = 0;
    row0 = '0; col0 = '0; row1 = '0; col1 = '0;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++)
        mem[i][j] = bit'($urandom_range(0, 1));

    tick(); mid();
    chk("lit_rst_oe", maze_oe, 0);
    chk("lit_rst_gcnt0", gcnt0, 0);
    tick(); rst_n = 1;

    // single read by solver 0 at (5,7)
    mem[5][7] = 1;
    req0 = 1; we0 = 0; row0 = 6'd5; col0 = 6'd7;
    mid(); chk("lit_t1_gnt0", gnt0, 1);
    tick(); req0 = 0;
    mid();
    chk("lit_t1_row", row, 5);
    chk("lit_t1_col", col, 7);
    chk("lit_t1_oe", maze_oe, 1);
    tick(); mid();
    chk("lit_t1_rvalid0", rvalid0, 1);
    chk("lit_t1_rdata0", rdata0, 1);
    chk("lit_t1_gcnt0", gcnt0, 1);
    chk("lit_t1_rvalid1", rvalid1, 0);
    tick(); mid();
    chk("lit_t1_pulse", rvalid0, 0);

    // write by solver 1 at (0,3)
    tick(); req1 = 1; we1 = 1; row1 = 6'd0; col1 = 6'd3;
    mid(); chk("lit_t3_gnt1", gnt1, 1);
    tick(); req1 = 0; we1 = 0;
    mid();
    chk("lit_t3_we", maze_we, 1);
    chk("lit_t3_oe", maze_oe, 0);
    chk("lit_t3_row", row, 0);
    chk("lit_t3_col", col, 3);
    tick(); mid();
    chk("lit_t3_rvalid1", rvalid1, 0);

    // both requesting for 4 cycles from a fresh reset
    tick(); do_reset();
    req0 = 1; req1 = 1;
    for (int k = 0; k < 4; k++) begin
      row0 = 6'($urandom_range(0, 63)); col0 = 6'($urandom_range(0, 63));
      row1 = 6'($urandom_range(0, 63)); col1 = 6'($urandom_range(0, 63));
      mid();
      chk("lit_t2_gnt0", gnt0, (k % 2) == 0);
      chk("lit_t2_gnt1", gnt1, (k % 2) == 1);
      tick();
    end
    idle();
    mid();
    chk("lit_t2_c4_rv0", rvalid0, 1);
    chk("lit_t2_c4_rv1", rvalid1, 0);
    tick(); mid();
    chk("lit_t2_c5_rv0", rvalid0, 0);
    chk("lit_t2_c5_rv1", rvalid1, 1);
    chk("lit_t2_gcnt0", gcnt0, 2);
    chk("lit_t2_gcnt1", gcnt1, 2);

    // back-to-back reads by solver 0 at (2,2), (2,3)
    tick();
    mem[2][2] = 0; mem[2][3] = 1;
    req0 = 1; we0 = 0; row0 = 6'd2; col0 = 6'd2;
    mid(); chk("lit_t4_gnt0a", gnt0, 1);
    tick(); col0 = 6'd3;
    mid(); chk("lit_t4_gnt0b", gnt0, 1);
    tick(); req0 = 0;
    mid();
    chk("lit_t4_rv0a", rvalid0, 1);
    chk("lit_t4_rd0a", rdata0, 0);
    tick(); mid();
    chk("lit_t4_rv0b", rvalid0, 1);
    chk("lit_t4_rd0b", rdata0, 1);

    // reset in the cycle after a read grant
    tick(); req0 = 1; we0 = 0; row0 = 6'd9; col0 = 6'd4;
    mid(); chk("lit_t5_gnt0", gnt0, 1);
    tick(); rst_n = 0; req0 = 0;
    mid();
    chk("lit_t5_oe", maze_oe, 0);
    chk("lit_t5_row", row, 0);
    chk("lit_t5_gcnt0", gcnt0, 0);
    tick(); mid();
    tick(); rst_n = 1; mid();
    chk("lit_t5_rv0a", rvalid0, 0);
    tick(); mid();
    chk("lit_t5_rv0b", rvalid0, 0);
    tick(); req0 = 1; req1 = 1;
    mid();
    chk("lit_t5_gnt0", gnt0, 1);
    chk("lit_t5_gnt1", gnt1, 0);
    tick(); req0 = 0;
    mid(); chk("lit_t5_gnt1b", gnt1, 1);
    tick(); idle();

    // five grants into the 2-bit counter
    do_reset();
    req0 = 1; we0 = 0;
    for (int k = 0; k < 5; k++) begin
      row0 = 6'(k);
      tick();
    end
    idle();
    mid();
    chk("lit_t6_sat", s_gcnt0, 3);
    chk("lit_t6_full", gcnt0, 5);

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      mid();
      g0 = gnt0; g1 = gnt1;
      tick();
      noise = 1'($urandom_range(0, 1));
      if (!rst_n) begin
        rst_n = 1;
      end else if ($urandom_range(0, 149) == 0) begin
        rst_n = 0;
        idle();
      end
      if (rst_n) begin
        if (!(req0 && !g0)) begin
          req0 = ($urandom_range(0, 99) < 60);
          we0  = ($urandom_range(0, 3) == 0);
          row0 = 6'($urandom_range(0, 63));
          col0 = 6'($urandom_range(0, 63));
        end
        if (!(req1 && !g1)) begin
          req1 = ($urandom_range(0, 99) < 60);
          we1  = ($urandom_range(0, 3) == 0);
          row1 = 6'($urandom_range(0, 63));
          col1 = 6'($urandom_range(0, 63));
        end
      end
    end

    tick(); idle();
    mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/maze_mem_arbiter.md
# maze_mem_arbiter

Two-port arbiter that shares the single maze memory port (row/col address, maze_oe read strobe, maze_we mark strobe, maze_in read data) between two maze solver instances. Requests are granted round-robin, one per clock, and issued on a registered memory port. Read data returns to the issuing solver two cycles after grant. The block sits between the solvers and the maze memory model, so two solvers can traverse the same maze concurrently.

## Interface
- maze_width, 6, width of row and col coordinates
- cnt_width, 16, width of the per-requester grant counters
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- req0, req1  in  1  access request from solver 0 / 1; held until granted
- we0, we1  in  1  1 = mark (write) access, 0 = read access; valid with req
- row0, col0, row1, col1  in  maze_width each  coordinates; valid with req
- gnt0, gnt1  out  1  combinational; request accepted at this clock edge
- rdata0, rdata1  out  1  registered read result (1 = wall)
- rvalid0, rvalid1  out  1  one-cycle pulse; rdata valid
- row, col  out  maze_width each  registered memory address
- maze_oe  out  1  registered memory read strobe
- maze_we  out  1  registered memory write (mark) strobe
- maze_in  in  1  memory read data; valid in the cycle maze_oe is high
- gcnt0, gcnt1  out  cnt_width each  granted-request counters; saturate at all-ones

## Operation
- Arbitration: pointer prio (0 or 1). If exactly one req is high, that requester wins. If both are high, requester prio wins. No req: no grant.
- gntX = reqX AND wins. At most one gnt per cycle.
- After a grant to X, prio becomes the other requester. prio is unchanged in cycles without a grant.
- Issue stage (registered), on the grant edge:
  - row/col load the winner's coordinates.
  - maze_oe = NOT we and maze_we = we of the winner.
  - tag = winner id.
- Without a grant, maze_oe and maze_we load 0, and row/col hold their previous value.
- Response stage (registered): in a cycle with maze_oe high, the next edge loads rdata[tag] = maze_in and pulses rvalid[tag] = 1 for one cycle.
- The other rdata holds its value. Writes produce no rvalid.
- gcntX increments on every gntX edge and saturates.
- maze_oe and maze_we are never high together.

## Timing
- Reset (rst_n low, asynchronous):
  - row = 0, col = 0, maze_oe = 0, maze_we = 0.
  - rdata0/1 = 0, rvalid0/1 = 0, gcnt0/1 = 0, prio = 0, tag = 0.
  - gnt0/1 = 0 while reset is held.
- Cycle N: gntX high. Edge N→N+1: the request is accepted.
- Cycle N+1: row/col/maze_oe/maze_we drive the memory. maze_in is sampled at the end of N+1.
- Cycle N+2: rvalidX high and rdataX valid. Read latency from grant is 2 cycles.
- Throughput is one access per cycle. Back-to-back grants form a 2-deep pipeline, and each response carries its own tag.
- A requester may re-request in N+1, before its previous rvalid; responses return in grant order.
- Reset mid-operation: in-flight issue and response stages are discarded (no rvalid after reset release), and prio returns to 0.
- Releasing req before grant is a protocol violation; the behaviour is undefined and it is not checked.

## Test plan
- Reset, then only req0 read at (5,7), maze_in = 1 during the issue cycle:
  - gnt0 in cycle 0.
  - row = 5, col = 7, maze_oe = 1 in cycle 1.
  - rvalid0 = 1, rdata0 = 1 in cycle 2.
  - gcnt0 = 1, and rvalid1 is never seen.
- req0 and req1 both held high for 4 cycles:
  - grants alternate 0,1,0,1 with prio starting at 0.
  - rvalid pulses follow 2 cycles later with the matching tags.
  - gcnt0 = gcnt1 = 2.
- req1 write (we1 = 1) at (0,3):
  - the issue cycle shows maze_we = 1, maze_oe = 0, row = 0, col = 3.
  - no rvalid1 appears.
- Back-to-back reads by solver 0 at (2,2) then (2,3), with maze_in = 0 then 1:
  - rvalid0 is high on two consecutive cycles.
  - rdata0 = 0, then 1.
- Assert rst_n low in the cycle after a read grant:
  - all outputs clear immediately.
  - no rvalid appears after release.
  - the next simultaneous request goes to requester 0.
- Preload gcnt0 near saturation with cnt_width = 2, then issue 5 grants: gcnt0 stops at 3.
